// File: rtl/spi_slave_shift_if.sv
// Pin-level SPI signals plus the byte-stream handshake between the SPI slave shifter
// and its host logic.
interface spi_slave_shift_if;
    logic       sclk_in;
    logic       ss_in;
    logic       mosi_in;
    logic       miso;
    logic       miso_oe;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_abort;
    logic       busy;

    modport slave (
        input  sclk_in, ss_in, mosi_in, cpol, cpha, lsbfe, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );

    modport master (
        output sclk_in, ss_in, mosi_in, cpol, cpha, lsbfe, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort, busy
    );
endinterface

// File: rtl/spi_slave_shift.sv
// SPI slave shifter: synchronises SCLK/SS/MOSI into PCLK, assembles received bytes and
// serialises a one-entry transmit buffer onto MISO in any CPOL/CPHA mode.
module spi_slave_shift #(
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input logic              PCLK,
    input logic              PRESET,
    spi_slave_shift_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic sclk_meta, sclk_sync, sclk_d;
    logic ss_meta, ss_sync;
    logic mosi_meta, mosi_sync;

    logic       cpol_q, cpha_q, lsbfe_q;
    logic       first_skip;
    logic [7:0] tx_shift, rx_shift, rx_next;
    logic [2:0] tx_cnt, rx_cnt;
    logic [7:0] buf_q;
    logic       buf_full;
    logic [7:0] reload_byte;

    logic in_load, in_xfer, oe, bsy;
    logic sclk_edge, lead_edge, trail_edge;
    logic ss_rise, do_sample, byte_done, shift_raw, shift_ev, do_reload, do_shift;

    logic       miso_q, rx_valid_q, underrun_q, abort_q;
    logic [7:0] rx_data_q;

    // NOTE: clocked processes use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sclk_meta <= bus.cpol;
            sclk_sync <= bus.cpol;
            sclk_d    <= bus.cpol;
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= bus.sclk_in;
            sclk_sync <= sclk_meta;
            sclk_d    <= sclk_sync;
            ss_meta   <= bus.ss_in;
            ss_sync   <= ss_meta;
            mosi_meta <= bus.mosi_in;
            mosi_sync <= mosi_meta;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!ss_sync) state_nxt = LOAD;
            LOAD:    state_nxt = XFER;
            XFER:    if (ss_sync) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_load = 1'b0;
        in_xfer = 1'b0;
        oe      = 1'b0;
        bsy     = 1'b0;
        case (state)
            LOAD: begin
                in_load = 1'b1;
                oe      = 1'b1;
                bsy     = 1'b1;
            end
            XFER: begin
                in_xfer = 1'b1;
                oe      = 1'b1;
                bsy     = 1'b1;
            end
            default: ;
        endcase
    end

    // Leading edge leaves the captured idle level, trailing edge returns to it.
    assign sclk_edge  = sclk_sync ^ sclk_d;
    assign lead_edge  = sclk_edge && (sclk_d == cpol_q);
    assign trail_edge = sclk_edge && (sclk_sync == cpol_q);

    assign ss_rise   = in_xfer && ss_sync;
    assign do_sample = in_xfer && (cpha_q ? trail_edge : lead_edge);
    assign byte_done = do_sample && (rx_cnt == 3'd7);
    assign shift_raw = in_xfer && !ss_sync && (cpha_q ? lead_edge : trail_edge);
    assign shift_ev  = shift_raw && !first_skip;
    assign do_reload = in_load || (shift_ev && (tx_cnt == 3'd7));
    assign do_shift  = shift_ev && (tx_cnt != 3'd7);
    assign rx_next   = lsbfe_q ? {mosi_sync, rx_shift[7:1]} : {rx_shift[6:0], mosi_sync};

    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        reload_byte = DEFAULT_TX;
        if (buf_full)          reload_byte = buf_q;
        else if (bus.tx_valid) reload_byte = bus.tx_data;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsbfe_q    <= 1'b0;
            first_skip <= 1'b0;
            tx_shift   <= 8'h00;
            tx_cnt     <= 3'd0;
            rx_shift   <= 8'h00;
            rx_cnt     <= 3'd0;
            // NOTE: the one-entry buffer is a plain register, so it is cleared like any other state.
            buf_q      <= 8'h00;
            buf_full   <= 1'b0;
            miso_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_valid_q <= byte_done;
            underrun_q <= do_reload && !buf_full && !bus.tx_valid;
            abort_q    <= ss_rise && (rx_cnt != 3'd0) && !byte_done;

            if (in_load) begin
                cpol_q     <= bus.cpol;
                cpha_q     <= bus.cpha;
                lsbfe_q    <= bus.lsbfe;
                first_skip <= bus.cpha;
            end else if (shift_raw) begin
                first_skip <= 1'b0;
            end

            if (do_reload) begin
                tx_shift <= reload_byte;
                tx_cnt   <= 3'd0;
            end else if (do_shift) begin
                tx_shift <= lsbfe_q ? (tx_shift >> 1) : (tx_shift << 1);
                tx_cnt   <= tx_cnt + 3'd1;
            end

            if (in_load) begin
                rx_cnt <= 3'd0;
            end else begin
                if (do_sample) begin
                    rx_shift <= rx_next;
                    rx_cnt   <= rx_cnt + 3'd1;
                end
                if (ss_rise) rx_cnt <= 3'd0;
            end
            if (byte_done) rx_data_q <= rx_next;

            if (do_reload && buf_full) begin
                buf_full <= 1'b0;
            end else if (bus.tx_valid && !buf_full && !do_reload) begin
                buf_q    <= bus.tx_data;
                buf_full <= 1'b1;
            end

            if (in_xfer && !ss_sync) miso_q <= lsbfe_q ? tx_shift[0] : tx_shift[7];
            else                     miso_q <= 1'b0;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = oe;
    assign bus.busy        = bsy;
    assign bus.tx_ready    = !buf_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: a table of single-byte frames, directed corner cases and
// randomised multi-byte frames compared against a byte-level SPI master model.
module tb_spi_slave_shift;
    localparam int         HALF  = 8;
    localparam int         SETUP = 16;
    localparam int         GAP   = 12;
    localparam int         TMO   = 4000;
    localparam logic [7:0] DFLT  = 8'hFF;

    typedef struct {
        bit         cpol;
        bit         cpha;
        bit         lsbfe;
        bit         preload;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_under;
    } vec_t;

    logic PCLK = 1'b0;
    logic PRESET;

    spi_slave_shift_if sif ();
    spi_slave_shift #(.DEFAULT_TX(DFLT)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(sif));

    always #5 PCLK = ~PCLK;

    int         n_checks = 0;
    int         n_err    = 0;
    int         n_under  = 0;
    int         n_abort  = 0;
    logic [7:0] rx_got[$];
    logic [7:0] mo_bytes[4];
    logic [7:0] mi_bytes[4];
    logic [7:0] txb[4];
    vec_t       vecs[6];
    logic       seen_oe, seen_busy, seen_ready, end_oe, end_busy;

    always @(negedge PCLK) begin
        if (sif.rx_valid === 1'b1)    rx_got.push_back(sif.rx_data);
        if (sif.tx_underrun === 1'b1) n_under++;
        if (sif.frame_abort === 1'b1) n_abort++;
    end

    initial begin
        repeat (60000) @(posedge PCLK);
        $display("FAIL watchdog: bench still running after 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int t;
        t = 0;
        while (sif.tx_ready !== 1'b1 && t < TMO) begin
            wait_clk(1);
            t++;
        end
        check("tx_ready_wait", t < TMO, 1);
        sif.tx_data  = d;
        sif.tx_valid = 1'b1;
        wait_clk(1);
        sif.tx_valid = 1'b0;
    endtask

    // Master side: drives nbits from mo_bytes, captures MISO into mi_bytes.
    task automatic spi_xfer(input bit pol, input bit pha, input bit lsb, input int nbits);
        int idx;
        sif.cpol    = pol;
        sif.cpha    = pha;
        sif.lsbfe   = lsb;
        sif.sclk_in = pol;
        wait_clk(8);
        sif.ss_in = 1'b0;
        wait_clk(SETUP);
        for (int b = 0; b < nbits; b++) begin
            idx = lsb ? (b % 8) : (7 - (b % 8));
            if (!pha) begin
                sif.mosi_in = mo_bytes[b / 8][idx];
                wait_clk(HALF);
                mi_bytes[b / 8][idx] = sif.miso;
                sif.sclk_in = ~pol;
                wait_clk(HALF);
                sif.sclk_in = pol;
            end else begin
                sif.sclk_in = ~pol;
                sif.mosi_in = mo_bytes[b / 8][idx];
                wait_clk(HALF);
                mi_bytes[b / 8][idx] = sif.miso;
                sif.sclk_in = pol;
                wait_clk(HALF);
            end
            if (b == 0) begin
                seen_oe    = sif.miso_oe;
                seen_busy  = sif.busy;
                seen_ready = sif.tx_ready;
            end
        end
        wait_clk(HALF);
        sif.ss_in = 1'b1;
        wait_clk(4);
        end_oe   = sif.miso_oe;
        end_busy = sif.busy;
        wait_clk(GAP);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},        sif.miso, 0);
        check({tag, "_miso_oe"},     sif.miso_oe, 0);
        check({tag, "_rx_data"},     sif.rx_data, 8'h00);
        check({tag, "_rx_valid"},    sif.rx_valid, 0);
        check({tag, "_tx_ready"},    sif.tx_ready, 1);
        check({tag, "_tx_underrun"}, sif.tx_underrun, 0);
        check({tag, "_frame_abort"}, sif.frame_abort, 0);
        check({tag, "_busy"},        sif.busy, 0);
    endtask

    initial begin
        int base, ub, ab, nb, reloads;
        bit rp, rh, rl;

        PRESET       = 1'b1;
        sif.ss_in    = 1'b1;
        sif.sclk_in  = 1'b0;
        sif.mosi_in  = 1'b0;
        sif.cpol     = 1'b0;
        sif.cpha     = 1'b0;
        sif.lsbfe    = 1'b0;
        sif.tx_data  = 8'h00;
        sif.tx_valid = 1'b0;

        //          cpol  cpha  lsbfe pre   tx     mosi   exp_rx exp_miso under
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h5A, 8'h5A, 8'h81, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 8'h96, 8'hFF, 2};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h6B, 8'hE1, 8'hE1, 8'h6B, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h70, 8'h70, 8'h0F, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hC4, 8'hC4, 8'hFF, 1};

        wait_clk(3);
        check_reset_outputs("por");
        PRESET = 1'b0;
        wait_clk(2);

        for (int i = 0; i < 6; i++) begin
            base = rx_got.size();
            ub   = n_under;
            ab   = n_abort;
            if (vecs[i].preload) write_tx(vecs[i].tx);
            mo_bytes[0] = vecs[i].mosi;
            spi_xfer(vecs[i].cpol, vecs[i].cpha, vecs[i].lsbfe, 8);
            check($sformatf("vec%0d_rx_count", i), rx_got.size() - base, 1);
            if (rx_got.size() > base) check($sformatf("vec%0d_rx_data", i), rx_got[base], vecs[i].exp_rx);
            check($sformatf("vec%0d_miso", i), mi_bytes[0], vecs[i].exp_miso);
            check($sformatf("vec%0d_underrun", i), n_under - ub, vecs[i].exp_under);
            check($sformatf("vec%0d_abort", i), n_abort - ab, 0);
            check($sformatf("vec%0d_oe_frame", i), seen_oe, 1);
            check($sformatf("vec%0d_busy_frame", i), seen_busy, 1);
            check($sformatf("vec%0d_ready_frame", i), seen_ready, 1);
            check($sformatf("vec%0d_oe_end", i), end_oe, 0);
            check($sformatf("vec%0d_busy_end", i), end_busy, 0);
        end

        // Two bytes in one frame; a write while the buffer is full must be dropped.
        base = rx_got.size();
        ub   = n_under;
        write_tx(8'h12);
        check("dual_full_ready", sif.tx_ready, 0);
        sif.tx_data  = 8'h77;
        sif.tx_valid = 1'b1;
        wait_clk(1);
        sif.tx_valid = 1'b0;
        mo_bytes[0] = 8'hA1;
        mo_bytes[1] = 8'hB2;
        fork
            spi_xfer(1'b0, 1'b0, 1'b0, 16);
            write_tx(8'h34);
        join
        check("dual_rx_count", rx_got.size() - base, 2);
        if (rx_got.size() >= base + 2) begin
            check("dual_rx0", rx_got[base], 8'hA1);
            check("dual_rx1", rx_got[base + 1], 8'hB2);
        end
        check("dual_miso0", mi_bytes[0], 8'h12);
        check("dual_miso1", mi_bytes[1], 8'h34);
        check("dual_underrun", n_under - ub, 1);
        check("dual_ready_end", sif.tx_ready, 1);

        // SS raised after five SCLK cycles.
        base = rx_got.size();
        ab   = n_abort;
        write_tx(8'h5E);
        mo_bytes[0] = 8'hFF;
        spi_xfer(1'b0, 1'b0, 1'b0, 5);
        check("abort_pulse", n_abort - ab, 1);
        check("abort_no_rx", rx_got.size() - base, 0);
        check("abort_rx_hold", sif.rx_data, 8'hB2);
        check("abort_oe_end", end_oe, 0);
        check("abort_busy_end", end_busy, 0);

        // PRESET mid-byte with a byte sitting in the transmit buffer.
        mo_bytes[0] = 8'h99;
        fork
            spi_xfer(1'b0, 1'b1, 1'b0, 8);
            begin
                wait_clk(40);
                write_tx(8'h55);
                wait_clk(30);
                PRESET = 1'b1;
                wait_clk(2);
                check_reset_outputs("midrst");
            end
        join
        wait_clk(2);
        PRESET = 1'b0;
        wait_clk(2);
        base = rx_got.size();
        ub   = n_under;
        ab   = n_abort;
        write_tx(8'h3C);
        mo_bytes[0] = 8'hC3;
        spi_xfer(1'b0, 1'b1, 1'b0, 8);
        check("post_rst_rx_count", rx_got.size() - base, 1);
        if (rx_got.size() > base) check("post_rst_rx", rx_got[base], 8'hC3);
        check("post_rst_miso", mi_bytes[0], 8'h3C);
        check("post_rst_underrun", n_under - ub, 0);
        check("post_rst_abort", n_abort - ab, 0);

        // Randomised frames: every supplied byte must appear on MISO in order,
        // and each reload point without a byte available costs one underrun.
        for (int f = 0; f < 6; f++) begin
            rp = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                txb[k]      = 8'($urandom);
                mo_bytes[k] = 8'($urandom);
            end
            base = rx_got.size();
            ub   = n_under;
            ab   = n_abort;
            write_tx(txb[0]);
            fork
                spi_xfer(rp, rh, rl, nb * 8);
                begin
                    for (int k = 1; k < nb; k++) write_tx(txb[k]);
                end
            join
            reloads = 1 + (rh ? nb - 1 : nb);
            check($sformatf("rnd%0d_rx_count", f), rx_got.size() - base, nb);
            for (int k = 0; k < nb; k++) begin
                if (rx_got.size() > base + k)
                    check($sformatf("rnd%0d_rx%0d", f, k), rx_got[base + k], mo_bytes[k]);
                check($sformatf("rnd%0d_miso%0d", f, k), mi_bytes[k], txb[k]);
            end
            check($sformatf("rnd%0d_underrun", f), n_under - ub, reloads - nb);
            check($sformatf("rnd%0d_abort", f), n_abort - ab, 0);
            check($sformatf("rnd%0d_busy_end", f), end_busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
